lieat_exu_com_wbck: RTL and testbench



---
 rtl/lieat_exu_com_wbck_pkg.sv | 21 ++
 rtl/lieat_exu_com_wbck_hold.sv | 42 ++++
 rtl/lieat_general_dfflr.sv | 23 ++
 rtl/lieat_exu_com_wbck.sv | 140 ++++++++++++++
 tb/tb_lieat_exu_com_wbck.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lieat_exu_com_wbck_pkg.sv
// Shared constants for the lieat EXU commit writeback arbiter.
//   XLEN / RF_IDX   : datapath and register-index widths
//   WBCK_SRC_*      : holding-register slot numbers; a lower number means higher priority
//   wbck_fixed_prio : picks the one-hot lowest set bit of a request vector
package lieat_exu_com_wbck_pkg;
  localparam int XLEN         = 32;
  localparam int RF_IDX       = 5;
  localparam int WBCK_SRC_CSR = 0;
  localparam int WBCK_SRC_LSU = 1;
  localparam int WBCK_SRC_MDU = 2;
  localparam int WBCK_SRC_ALU = 3;
  localparam int WBCK_SRC_NUM = 4;

  // Slot 0 (CSR) wins. Isolating the lowest set bit gives the fixed priority
  // CSR > LSU > MDU > ALU without a priority chain.
  function automatic logic [WBCK_SRC_NUM-1:0] wbck_fixed_prio(
    input logic [WBCK_SRC_NUM-1:0] req
  );
    return req & (~req + {{(WBCK_SRC_NUM-1){1'b0}}, 1'b1});
  endfunction
endpackage

// File: rtl/lieat_exu_com_wbck_hold.sv
// One-entry result holding register for one writeback source.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load_i       : the source's result is accepted this cycle
//   rd_i, data_i : destination register and result value
//   grant_i      : the arbiter is writing this entry to the register file
//   vld_o        : the entry holds a pending write
//   rd_o, data_o : held destination register and result value
// A result aimed at x0 is accepted but never stored, so it never writes.
// A load in the same cycle as a grant replaces the granted entry.
module lieat_exu_com_wbck_hold
  import lieat_exu_com_wbck_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic [RF_IDX-1:0] rd_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic              grant_i,
  output logic              vld_o,
  output logic [RF_IDX-1:0] rd_o,
  output logic [XLEN-1:0]   data_o
);
  logic load_eff;

  assign load_eff = load_i & (rd_i != '0);

  // The valid bit changes on a real load (set) or a grant (clear); a load wins.
  lieat_general_dfflr #(.DW(1)) u_vld (
    .clk (clock), .rst (reset), .lden (load_eff | grant_i),
    .dnxt(load_eff), .qout(vld_o)
  );

  lieat_general_dfflr #(.DW(RF_IDX)) u_rd (
    .clk (clock), .rst (reset), .lden (load_eff),
    .dnxt(rd_i), .qout(rd_o)
  );

  lieat_general_dfflr #(.DW(XLEN)) u_data (
    .clk (clock), .rst (reset), .lden (load_eff),
    .dnxt(data_i), .qout(data_o)
  );
endmodule

// File: rtl/lieat_general_dfflr.sv
// Generic state flop with load enable and synchronous active-high reset to zero.
//   clk  : rising-edge clock
//   rst  : synchronous reset, clears qout
//   lden : load enable
//   dnxt : next value, loaded when lden is high
//   qout : registered value
module lieat_general_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end
endmodule

// File: rtl/lieat_exu_com_wbck.sv
// Commit-stage writeback arbiter: buffers CSR/LSU/MDU/ALU results in one-entry
// holding registers, grants one per cycle by fixed priority
// (CSR > LSU > MDU > ALU) and drives the registered register-file write port.
// Ports:
//   clock, reset                    : rising-edge clock, synchronous active-high reset
//   csr_o_valid/_data/_rd           : CSR result pulse, always accepted
//   {alu,lsu,mdu}_wb_valid/_ready   : valid/ready handshake; a transfer happens on the
//                                     cycle where both are high. ready = entry empty or
//                                     being granted, so it depends only on state.
//   {alu,lsu,mdu}_wb_rd/_data       : result destination and value
//   wbck_rf_wen/_idx/_wdata         : registered register-file write port
//   wbck_busy                       : any pending entry or a write in flight
//   wbck_perf_wr_cnt/_stall_cnt     : write and producer-stall counters, present only
//                                     when LIEAT_WBCK_PERF_EN is defined
module lieat_exu_com_wbck
  import lieat_exu_com_wbck_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              csr_o_valid,
  input  logic [XLEN-1:0]   csr_o_data,
  input  logic [RF_IDX-1:0] csr_o_rd,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [RF_IDX-1:0] alu_wb_rd,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [RF_IDX-1:0] lsu_wb_rd,
  input  logic [XLEN-1:0]   lsu_wb_data,
  input  logic              mdu_wb_valid,
  output logic              mdu_wb_ready,
  input  logic [RF_IDX-1:0] mdu_wb_rd,
  input  logic [XLEN-1:0]   mdu_wb_data,
  output logic              wbck_rf_wen,
  output logic [RF_IDX-1:0] wbck_rf_idx,
  output logic [XLEN-1:0]   wbck_rf_wdata,
  output logic              wbck_busy
`ifdef LIEAT_WBCK_PERF_EN
  ,
  output logic [31:0]       wbck_perf_wr_cnt,
  output logic [31:0]       wbck_perf_stall_cnt
`endif
);
  logic [WBCK_SRC_NUM-1:0] load;
  logic [WBCK_SRC_NUM-1:0] hold_vld;
  logic [WBCK_SRC_NUM-1:0] grant;
  logic [RF_IDX-1:0]       in_rd     [WBCK_SRC_NUM];
  logic [XLEN-1:0]         in_data   [WBCK_SRC_NUM];
  logic [RF_IDX-1:0]       hold_rd   [WBCK_SRC_NUM];
  logic [XLEN-1:0]         hold_data [WBCK_SRC_NUM];
  logic [RF_IDX-1:0]       grant_rd;
  logic [XLEN-1:0]         grant_data;
  logic                    any_grant;

  assign in_rd[WBCK_SRC_CSR]   = csr_o_rd;
  assign in_rd[WBCK_SRC_LSU]   = lsu_wb_rd;
  assign in_rd[WBCK_SRC_MDU]   = mdu_wb_rd;
  assign in_rd[WBCK_SRC_ALU]   = alu_wb_rd;
  assign in_data[WBCK_SRC_CSR] = csr_o_data;
  assign in_data[WBCK_SRC_LSU] = lsu_wb_data;
  assign in_data[WBCK_SRC_MDU] = mdu_wb_data;
  assign in_data[WBCK_SRC_ALU] = alu_wb_data;

  // Ready looks only at held state and the grant, never at the valid inputs.
  assign lsu_wb_ready = ~hold_vld[WBCK_SRC_LSU] | grant[WBCK_SRC_LSU];
  assign mdu_wb_ready = ~hold_vld[WBCK_SRC_MDU] | grant[WBCK_SRC_MDU];
  assign alu_wb_ready = ~hold_vld[WBCK_SRC_ALU] | grant[WBCK_SRC_ALU];

  // CSR has no back-pressure: a pending CSR entry is always granted the cycle
  // after capture, so the holding register is free whenever the next pulse arrives.
  assign load[WBCK_SRC_CSR] = csr_o_valid;
  assign load[WBCK_SRC_LSU] = lsu_wb_valid & lsu_wb_ready;
  assign load[WBCK_SRC_MDU] = mdu_wb_valid & mdu_wb_ready;
  assign load[WBCK_SRC_ALU] = alu_wb_valid & alu_wb_ready;

  for (genvar g = 0; g < WBCK_SRC_NUM; g++) begin : g_hold
    lieat_exu_com_wbck_hold u_hold (
      .clock  (clock),
      .reset  (reset),
      .load_i (load[g]),
      .rd_i   (in_rd[g]),
      .data_i (in_data[g]),
      .grant_i(grant[g]),
      .vld_o  (hold_vld[g]),
      .rd_o   (hold_rd[g]),
      .data_o (hold_data[g])
    );
  end

  assign grant     = wbck_fixed_prio(hold_vld);
  assign any_grant = |grant;

  // Grant is one-hot (or zero), so an AND-OR mux selects the winner.
  always_comb begin
    grant_rd   = '0;
    grant_data = '0;
    for (int i = 0; i < WBCK_SRC_NUM; i++) begin
      grant_rd   = grant_rd   | ({RF_IDX{grant[i]}} & hold_rd[i]);
      grant_data = grant_data | ({XLEN{grant[i]}}   & hold_data[i]);
    end
  end

  lieat_general_dfflr #(.DW(1)) u_rf_wen (
    .clk (clock), .rst (reset), .lden (1'b1),
    .dnxt(any_grant), .qout(wbck_rf_wen)
  );

  // Index and data keep their last value when nothing is written.
  lieat_general_dfflr #(.DW(RF_IDX)) u_rf_idx (
    .clk (clock), .rst (reset), .lden (any_grant),
    .dnxt(grant_rd), .qout(wbck_rf_idx)
  );

  lieat_general_dfflr #(.DW(XLEN)) u_rf_wdata (
    .clk (clock), .rst (reset), .lden (any_grant),
    .dnxt(grant_data), .qout(wbck_rf_wdata)
  );

  assign wbck_busy = (|hold_vld) | wbck_rf_wen;

`ifdef LIEAT_WBCK_PERF_EN
  logic producer_stall;

  assign producer_stall = (alu_wb_valid & ~alu_wb_ready)
                        | (lsu_wb_valid & ~lsu_wb_ready)
                        | (mdu_wb_valid & ~mdu_wb_ready);

  // Counters wrap naturally at 32 bits.
  lieat_general_dfflr #(.DW(32)) u_perf_wr (
    .clk (clock), .rst (reset), .lden (wbck_rf_wen),
    .dnxt(wbck_perf_wr_cnt + 32'd1), .qout(wbck_perf_wr_cnt)
  );

  lieat_general_dfflr #(.DW(32)) u_perf_stall (
    .clk (clock), .rst (reset), .lden (producer_stall),
    .dnxt(wbck_perf_stall_cnt + 32'd1), .qout(wbck_perf_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_lieat_exu_com_wbck.sv
// Directed bench for lieat_exu_com_wbck. Define LIEAT_WBCK_PERF_EN to also
// exercise the performance counters.
module tb_lieat_exu_com_wbck;
  localparam int XW = 32;
  localparam int RW = 5;
  localparam int W  = RW + XW;

  logic          clock;
  logic          reset;
  logic          csr_o_valid;
  logic [XW-1:0] csr_o_data;
  logic [RW-1:0] csr_o_rd;
  logic          alu_wb_valid, alu_wb_ready;
  logic [RW-1:0] alu_wb_rd;
  logic [XW-1:0] alu_wb_data;
  logic          lsu_wb_valid, lsu_wb_ready;
  logic [RW-1:0] lsu_wb_rd;
  logic [XW-1:0] lsu_wb_data;
  logic          mdu_wb_valid, mdu_wb_ready;
  logic [RW-1:0] mdu_wb_rd;
  logic [XW-1:0] mdu_wb_data;
  logic          wbck_rf_wen;
  logic [RW-1:0] wbck_rf_idx;
  logic [XW-1:0] wbck_rf_wdata;
  logic          wbck_busy;
`ifdef LIEAT_WBCK_PERF_EN
  logic [31:0]   wbck_perf_wr_cnt;
  logic [31:0]   wbck_perf_stall_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  lieat_exu_com_wbck dut (
    .clock        (clock),
    .reset        (reset),
    .csr_o_valid  (csr_o_valid),
    .csr_o_data   (csr_o_data),
    .csr_o_rd     (csr_o_rd),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_rd    (alu_wb_rd),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_rd    (lsu_wb_rd),
    .lsu_wb_data  (lsu_wb_data),
    .mdu_wb_valid (mdu_wb_valid),
    .mdu_wb_ready (mdu_wb_ready),
    .mdu_wb_rd    (mdu_wb_rd),
    .mdu_wb_data  (mdu_wb_data),
    .wbck_rf_wen  (wbck_rf_wen),
    .wbck_rf_idx  (wbck_rf_idx),
    .wbck_rf_wdata(wbck_rf_wdata),
    .wbck_busy    (wbck_busy)
`ifdef LIEAT_WBCK_PERF_EN
    ,
    .wbck_perf_wr_cnt   (wbck_perf_wr_cnt),
    .wbck_perf_stall_cnt(wbck_perf_stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    csr_o_valid = 0; csr_o_rd = '0; csr_o_data = '0;
    alu_wb_valid = 0; alu_wb_rd = '0; alu_wb_data = '0;
    lsu_wb_valid = 0; lsu_wb_rd = '0; lsu_wb_data = '0;
    mdu_wb_valid = 0; mdu_wb_rd = '0; mdu_wb_data = '0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // CSR must never pulse while its entry is pending and ungranted.
  always @(negedge clock) begin
    if (!reset && csr_o_valid) begin
      n_total++;
      if (dut.hold_vld[0] && !dut.grant[0])
        $display("FAIL csr_invariant: hold_vld=1 grant=0 while csr_o_valid=1 at %0t", $time);
      else
        n_pass++;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset;
    clear_inputs();
    do_reset();
    n_total++;
    if ({wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata, wbck_busy} !== {1'b0, 5'd0, 32'd0, 1'b0})
      $display("FAIL reset_out: got wen=%0b idx=%0d data=%h busy=%0b want all zero",
               wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata, wbck_busy);
    else n_pass++;
    n_total++;
    if ({lsu_wb_ready, mdu_wb_ready, alu_wb_ready} !== 3'b111)
      $display("FAIL reset_ready: got %b want 111", {lsu_wb_ready, mdu_wb_ready, alu_wb_ready});
    else n_pass++;
`ifdef LIEAT_WBCK_PERF_EN
    n_total++;
    if ({wbck_perf_wr_cnt, wbck_perf_stall_cnt} !== 64'd0)
      $display("FAIL reset_perf: got wr=%0d stall=%0d want 0 0", wbck_perf_wr_cnt, wbck_perf_stall_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_single_alu;
    alu_wb_valid = 1; alu_wb_rd = 5'd5; alu_wb_data = 32'h1234;
    tick;                                   // edge 0: accepted
    clear_inputs();
    n_total++;
    if ({wbck_rf_wen, wbck_busy} !== 2'b01)
      $display("FAIL alu_e0: got wen=%0b busy=%0b want wen=0 busy=1", wbck_rf_wen, wbck_busy);
    else n_pass++;
    tick;                                   // edge 1: written
    n_total++;
    if ({wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL alu_write: got wen=%0b idx=%0d data=%h want 1 5 00001234",
               wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata);
    else n_pass++;
    tick;                                   // edge 2: idle, idx/data hold
    n_total++;
    if ({wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata, wbck_busy} !== {1'b0, 5'd5, 32'h1234, 1'b0})
      $display("FAIL alu_idle: got wen=%0b idx=%0d data=%h busy=%0b want 0 5 00001234 0",
               wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata, wbck_busy);
    else n_pass++;
  endtask

  task automatic test_collision;
    logic [RW-1:0] exp_idx [4];
    logic [XW-1:0] exp_dat [4];
    logic [2:0]    exp_rdy [4];
    exp_idx[0] = 5'd1; exp_dat[0] = 32'hC0; exp_rdy[0] = 3'b100;
    exp_idx[1] = 5'd2; exp_dat[1] = 32'h10; exp_rdy[1] = 3'b110;
    exp_idx[2] = 5'd3; exp_dat[2] = 32'h20; exp_rdy[2] = 3'b111;
    exp_idx[3] = 5'd4; exp_dat[3] = 32'h30; exp_rdy[3] = 3'b111;
    csr_o_valid  = 1; csr_o_rd  = 5'd1; csr_o_data  = 32'hC0;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd2; lsu_wb_data = 32'h10;
    mdu_wb_valid = 1; mdu_wb_rd = 5'd3; mdu_wb_data = 32'h20;
    alu_wb_valid = 1; alu_wb_rd = 5'd4; alu_wb_data = 32'h30;
    n_total++;
    if ({lsu_wb_ready, mdu_wb_ready, alu_wb_ready} !== 3'b111)
      $display("FAIL coll_ready_pre: got %b want 111", {lsu_wb_ready, mdu_wb_ready, alu_wb_ready});
    else n_pass++;
    tick;
    clear_inputs();
    n_total++;
    if ({wbck_rf_wen, lsu_wb_ready, mdu_wb_ready, alu_wb_ready} !== 4'b0000)
      $display("FAIL coll_held: got wen=%0b ready=%b want wen=0 ready=000",
               wbck_rf_wen, {lsu_wb_ready, mdu_wb_ready, alu_wb_ready});
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      tick;
      n_total++;
      if ({wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata} !== {1'b1, exp_idx[k], exp_dat[k]})
        $display("FAIL coll_write%0d: got wen=%0b idx=%0d data=%h want 1 %0d %h",
                 k, wbck_rf_wen, wbck_rf_idx, wbck_rf_wdata, exp_idx[k], exp_dat[k]);
      else n_pass++;
      n_total++;
      if ({lsu_wb_ready, mdu_wb_ready, alu_wb_ready} !== exp_rdy[k])
        $display("FAIL coll_ready%0d: got %b want %b",
                 k, {lsu_wb_ready, mdu_wb_ready, alu_wb_ready}, exp_rdy[k]);
      else n_pass++;
    end
    tick;
    n_total++;
    if ({wbck_rf_wen, wbck_busy} !== 2'b00)
      $display("FAIL coll_drain: got wen=%0b busy=%0b want 0 0", wbck_rf_wen, wbck_busy);
    else n_pass++;
  endtask

  task automatic test_x0_drop;
    int bad;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd0; lsu_wb_data = 32'hDEAD;
    n_total++;
    if (lsu_wb_ready !== 1'b1)
      $display("FAIL x0_ready: got %0b want 1", lsu_wb_ready);
    else n_pass++;
    tick;
    clear_inputs();
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (wbck_rf_wen !== 1'b0 || wbck_busy !== 1'b0) bad++;
      tick;
    end
    n_total++;
    if (bad != 0)
      $display("FAIL x0_nowrite: got %0d cycles with wen/busy set want 0", bad);
    else n_pass++;
  endtask

  task automatic test_alu_stream;
    int n, lows;
    logic fire;
    logic [W-1:0] got;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({5'd7, 32'(i)});
      if (i == 2) exp_q.push_back({5'd9, 32'hC5});
    end
    n = 0; lows = 0;
    for (int c = 0; c < 16; c++) begin
      if (wbck_rf_wen === 1'b1) begin
        got = {wbck_rf_idx, wbck_rf_wdata};
        n_total++;
        if (exp_q.size() == 0)
          $display("FAIL stream_extra: got idx=%0d data=%h want no write", wbck_rf_idx, wbck_rf_wdata);
        else if (got !== exp_q[0]) begin
          $display("FAIL stream_write: got %h want %h", got, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
          n_pass++;
        end
      end
      csr_o_valid = (c == 3); csr_o_rd = 5'd9; csr_o_data = 32'hC5;
      alu_wb_valid = (n < 8); alu_wb_rd = 5'd7; alu_wb_data = 32'(n);
      if (alu_wb_valid && !alu_wb_ready) lows++;
      fire = alu_wb_valid & alu_wb_ready;
      tick;
      if (fire) n++;
    end
    clear_inputs();
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL stream_missing: got %0d writes outstanding want 0", exp_q.size());
    else n_pass++;
    n_total++;
    if (lows != 1)
      $display("FAIL stream_ready_low: got %0d cycles want 1", lows);
    else n_pass++;
  endtask

  task automatic test_reset_midflight;
    int bad;
    mdu_wb_valid = 1; mdu_wb_rd = 5'd3; mdu_wb_data = 32'h33;
    alu_wb_valid = 1; alu_wb_rd = 5'd4; alu_wb_data = 32'h44;
    tick;
    clear_inputs();
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_total++;
    if ({lsu_wb_ready, mdu_wb_ready, alu_wb_ready, wbck_rf_idx, wbck_rf_wdata} !== {3'b111, 5'd0, 32'd0})
      $display("FAIL rst_mid_state: got ready=%b idx=%0d data=%h want 111 0 0",
               {lsu_wb_ready, mdu_wb_ready, alu_wb_ready}, wbck_rf_idx, wbck_rf_wdata);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (wbck_rf_wen !== 1'b0 || wbck_busy !== 1'b0) bad++;
      tick;
    end
    n_total++;
    if (bad != 0)
      $display("FAIL rst_mid_nowrite: got %0d cycles with wen/busy set want 0", bad);
    else n_pass++;
`ifdef LIEAT_WBCK_PERF_EN
    n_total++;
    if ({wbck_perf_wr_cnt, wbck_perf_stall_cnt} !== 64'd0)
      $display("FAIL rst_mid_perf: got wr=%0d stall=%0d want 0 0", wbck_perf_wr_cnt, wbck_perf_stall_cnt);
    else n_pass++;
`endif
  endtask

`ifdef LIEAT_WBCK_PERF_EN
  task automatic test_perf;
    do_reset();
    csr_o_valid  = 1; csr_o_rd  = 5'd1; csr_o_data  = 32'h1;
    lsu_wb_valid = 1; lsu_wb_rd = 5'd2; lsu_wb_data = 32'h2;
    alu_wb_valid = 1; alu_wb_rd = 5'd4; alu_wb_data = 32'h4;
    tick;
    // ALU keeps offering an x0 result: blocked for two cycles, then dropped.
    csr_o_valid = 0; lsu_wb_valid = 0;
    alu_wb_rd = 5'd0; alu_wb_data = 32'hBAD;
    tick;
    tick;
    tick;
    clear_inputs();
    for (int k = 0; k < 5; k++) tick;
    n_total++;
    if (wbck_perf_wr_cnt !== 32'd3)
      $display("FAIL perf_wr: got %0d want 3", wbck_perf_wr_cnt);
    else n_pass++;
    n_total++;
    if (wbck_perf_stall_cnt !== 32'd2)
      $display("FAIL perf_stall: got %0d want 2", wbck_perf_stall_cnt);
    else n_pass++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_alu();
    test_collision();
    test_x0_drop();
    test_alu_stream();
    test_reset_midflight();
`ifdef LIEAT_WBCK_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
